fp_mul_pipe: RTL and testbench

//  Parametrised, fully pipelined floating-point multiplier with valid/ready flow control.

---
 rtl/fp_mul_pipe.sv | 146 ++++++++++++++
 tb/tb_fp_mul_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Four-stage floating-point multiplier {sign, exp, frac} with valid/ready flow control.
// Exponent 0 encodes signed zero; out-of-range results saturate or flush to zero.
module fp_mul_pipe #(
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 16,
  parameter int ROUND  = 1,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_overflow,
  output logic         out_underflow
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EMAX = 2**EXP_W - 1;
  localparam int EW2  = EXP_W + 2;
  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2*FRAC_W + 2;

  // Round-to-nearest-even increment decision from guard, sticky and lsb.
  function automatic logic round_inc(input logic guard, input logic sticky, input logic lsb);
    return (ROUND != 0) && guard && (sticky || lsb);
  endfunction

  logic adv_s;

  logic                s1_valid_r, s1_sign_r, s1_zero_r;
  logic [EXP_W-1:0]    s1_ea_r, s1_eb_r;
  logic [FRAC_W-1:0]   s1_fa_r, s1_fb_r;

  logic                s2_valid_r, s2_sign_r, s2_zero_r;
  logic [EW2-1:0]      s2_esum_r;
  logic [PW-1:0]       s2_prod_r;

  logic                s3_valid_r, s3_sign_r, s3_zero_r;
  logic [EW2-1:0]      s3_esum_r;
  logic [1:0]          s3_adj_r;
  logic [FRAC_W-1:0]   s3_frac_r;

  logic                out_valid_r, out_ovf_r, out_unf_r;
  logic [W-1:0]        out_p_r;

  logic [EW2-1:0]      s2_esum_s;
  logic [PW-1:0]       s2_prod_s;
  logic                s3_n_s, s3_guard_s, s3_sticky_s, s3_inc_s, s3_carry_s;
  logic [FRAC_W-1:0]   s3_frac_s, s3_frac_rnd_s;
  logic signed [EW2-1:0] s4_e_s;
  logic [W-1:0]        s4_p_s;
  logic                s4_ovf_s, s4_unf_s;

  // The whole pipe moves together; a full output that is not being taken freezes it.
  assign adv_s    = out_ready | ~out_valid_r;
  assign in_ready = adv_s;

  assign out_valid     = out_valid_r;
  assign out_p         = out_p_r;
  assign out_overflow  = out_ovf_r;
  assign out_underflow = out_unf_r;

  // Exponent sum and full mantissa product with the hidden ones restored.
  assign s2_esum_s = EW2'(s1_ea_r) + EW2'(s1_eb_r);
  assign s2_prod_s = PW'({1'b1, s1_fa_r}) * PW'({1'b1, s1_fb_r});

  // Normalise the [1,4) product, then round the kept fraction.
  always_comb begin
    s3_n_s = s2_prod_r[PW-1];
    if (s3_n_s) begin
      s3_frac_s   = s2_prod_r[PW-2 -: FRAC_W];
      s3_guard_s  = s2_prod_r[FRAC_W];
      s3_sticky_s = |s2_prod_r[FRAC_W-1:0];
    end else begin
      s3_frac_s   = s2_prod_r[PW-3 -: FRAC_W];
      s3_guard_s  = s2_prod_r[FRAC_W-1];
      s3_sticky_s = |s2_prod_r[FRAC_W-2:0];
    end
    s3_inc_s = round_inc(s3_guard_s, s3_sticky_s, s3_frac_s[0]);
    {s3_carry_s, s3_frac_rnd_s} = {1'b0, s3_frac_s} + MW'(s3_inc_s);
  end

  // Final exponent and range classification; the zero operand case wins over everything.
  always_comb begin
    s4_e_s   = $signed(s3_esum_r - EW2'(BIAS) + EW2'(s3_adj_r));
    s4_p_s   = {s3_sign_r, {(W-1){1'b0}}};
    s4_ovf_s = 1'b0;
    s4_unf_s = 1'b0;
    if (s3_zero_r) begin
      s4_p_s = {s3_sign_r, {(W-1){1'b0}}};
    end else if (s4_e_s > $signed(EW2'(EMAX))) begin
      s4_p_s   = {s3_sign_r, {(W-1){1'b1}}};
      s4_ovf_s = 1'b1;
    end else if (s4_e_s < $signed(EW2'(1))) begin
      s4_p_s   = {s3_sign_r, {(W-1){1'b0}}};
      s4_unf_s = 1'b1;
    end else begin
      s4_p_s = {s3_sign_r, s4_e_s[EXP_W-1:0], s3_frac_r};
    end
  end

  // Stage registers: valid bits and outputs clear on reset, everything shifts on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s2_valid_r  <= 1'b0;
      s3_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_p_r     <= {W{1'b0}};
      out_ovf_r   <= 1'b0;
      out_unf_r   <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      s1_sign_r  <= in_a[W-1] ^ in_b[W-1];
      s1_zero_r  <= (in_a[W-2 -: EXP_W] == {EXP_W{1'b0}}) || (in_b[W-2 -: EXP_W] == {EXP_W{1'b0}});
      s1_ea_r    <= in_a[W-2 -: EXP_W];
      s1_eb_r    <= in_b[W-2 -: EXP_W];
      s1_fa_r    <= in_a[FRAC_W-1:0];
      s1_fb_r    <= in_b[FRAC_W-1:0];

      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_zero_r  <= s1_zero_r;
      s2_esum_r  <= s2_esum_s;
      s2_prod_r  <= s2_prod_s;

      s3_valid_r <= s2_valid_r;
      s3_sign_r  <= s2_sign_r;
      s3_zero_r  <= s2_zero_r;
      s3_esum_r  <= s2_esum_r;
      s3_adj_r   <= 2'(s3_n_s) + 2'(s3_carry_s);
      s3_frac_r  <= s3_frac_rnd_s;

      out_valid_r <= s3_valid_r;
      out_p_r     <= s4_p_s;
      out_ovf_r   <= s4_ovf_s;
      out_unf_r   <= s4_unf_s;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: two instances (round-to-nearest-even and truncate) share the
// operand stream and are checked every cycle against an arithmetic reference model.
module tb_fp_mul_pipe;

  localparam int E    = 7;
  localparam int F    = 16;
  localparam int W    = 1 + E + F;
  localparam int BIAS = 63;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_ready0, out_valid0, ovf0, unf0;
  logic         in_ready1, out_valid1, ovf1, unf1;
  logic [W-1:0] p0, p1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepted = 0;
  int popped0  = 0;
  int last_acc_cyc = 0;

  logic [W+1:0] q0[$];
  logic [W+1:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mul_pipe #(.EXP_W(E), .FRAC_W(F), .ROUND(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_p(p0), .out_overflow(ovf0), .out_underflow(unf0));

  fp_mul_pipe #(.EXP_W(E), .FRAC_W(F), .ROUND(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_p(p1), .out_overflow(ovf1), .out_underflow(unf1));

  // Reference: exact integer product, divide down to F fraction bits, round on the remainder.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input int rnd);
    logic s;
    longint ea, eb, e, prod, q, rem, half;
    int sh;
    logic [W-1:0] p;
    s  = a[W-1] ^ b[W-1];
    ea = longint'(a[W-2:F]);
    eb = longint'(b[W-2:F]);
    if (ea == 0 || eb == 0) return {2'b00, s, {(W-1){1'b0}}};
    prod = ((longint'(1) << F) + longint'(a[F-1:0])) * ((longint'(1) << F) + longint'(b[F-1:0]));
    sh   = (prod >= (longint'(1) << (2*F+1))) ? F + 1 : F;
    e    = ea + eb - BIAS + (sh - F);
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rnd != 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q == (longint'(1) << (F+1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e > (1 << E) - 1) return {2'b10, s, {(W-1){1'b1}}};
    if (e < 1) return {2'b01, s, {(W-1){1'b0}}};
    p = {s, e[E-1:0], q[F-1:0]};
    return {2'b00, p};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
  endtask

  // Scoreboard: check the head result every valid cycle, pop on handshake, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid0) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_r1: got %h expected no result", p0);
        end else begin
          chk("result_r1", 64'({ovf0, unf0, p0}), 64'(q0[0]));
          if (out_ready) begin
            void'(q0.pop_front());
            popped0++;
          end
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_r0: got %h expected no result", p1);
        end else begin
          chk("result_r0", 64'({ovf1, unf1, p1}), 64'(q1[0]));
          if (out_ready) void'(q1.pop_front());
        end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(model(in_a, in_b, 1));
        accepted++;
        last_acc_cyc = cyc;
      end
      if (in_valid && in_ready1) q1.push_back(model(in_a, in_b, 0));
    end
  end

  logic [W-1:0] va[10];
  logic [W-1:0] vb[10];

  initial begin
    int t, base, pbase, cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid0", 64'(out_valid0), 64'd0);
    chk("rst_out_valid1", 64'(out_valid1), 64'd0);
    chk("rst_out_p", 64'({ovf0, unf0, p0}), 64'd0);
    chk("rst_in_ready", 64'({in_ready0, in_ready1}), 64'd3);

    // Hand-computed values pinning the model.
    chk("m_1p5sq",   64'(model(24'h3F8000, 24'h3F8000, 1)), 64'h0402000);
    chk("m_neg2",    64'(model(24'h3F0000, 24'hC00000, 1)), 64'h0C00000);
    chk("m_negzero", 64'(model(24'h000000, 24'hBF8000, 1)), 64'h0800000);
    chk("m_ovf",     64'(model(24'h7F0000, 24'h7F0000, 1)), 64'h27FFFFF);
    chk("m_unf",     64'(model(24'h010000, 24'h010000, 1)), 64'h1000000);
    chk("m_tie_rne", 64'(model(24'h3F0001, 24'h3F8000, 1)), 64'h03F8002);
    chk("m_tie_trn", 64'(model(24'h3F0001, 24'h3F8000, 0)), 64'h03F8001);

    // Latency and first result.
    @(posedge clk);
    #2;
    send(24'h3F8000, 24'h3F8000);
    t = 0;
    while (!out_valid0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("latency", 64'(cyc - last_acc_cyc), 64'd4);
    chk("first_p", 64'({ovf0, unf0, p0}), 64'h0402000);
    drain();

    // Directed corner vectors back to back, then random operands.
    va = '{24'h3F0000, 24'h000000, 24'h7F0000, 24'h010000, 24'h3F0001,
           24'h3FFFFF, 24'hBF8000, 24'h3F7FFF, 24'h5F1234, 24'h200000};
    vb = '{24'hC00000, 24'hBF8000, 24'h7F0000, 24'h010000, 24'h3F8000,
           24'h3F0001, 24'hBF8000, 24'h3F8001, 24'h60ABCD, 24'h1F0000};
    for (int i = 0; i < 10; i++) send(va[i], vb[i]);
    for (int i = 0; i < 16; i++)
      send({1'($urandom), 7'($urandom_range(0, 127)), 16'($urandom)},
           {1'($urandom), 7'($urandom_range(0, 127)), 16'($urandom)});
    drain();

    // Back-pressure: pipe fills with four, rest waits, all eight come out in order.
    @(posedge clk);
    #2 out_ready = 1'b0;
    base  = accepted;
    pbase = popped0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(24'h3F0000 + 24'(i * 24'h1234), 24'h400000 + 24'(i * 24'h0777));
      end
      begin
        repeat (12) @(negedge clk);
        chk("stall_accepts", 64'(accepted - base), 64'd4);
        chk("stall_in_ready", 64'(in_ready0), 64'd0);
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_popped", 64'(popped0 - pbase), 64'd8);

    // Reset with three operations in flight.
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) send(24'h3F8000 + 24'(i), 24'h3F0000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_out_valid", 64'({out_valid0, out_valid1}), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(out_valid0) + int'(out_valid1);
    end
    chk("no_stale", 64'(cnt), 64'd0);

    // Recovery after flush.
    @(posedge clk);
    #2;
    send(24'h3F0001, 24'h3F8000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
